// File: rtl/conv_calc_pkg.sv
// rtl/conv_calc_pkg.sv - shared sizing helpers for the convolution window calculator
package conv_calc_pkg;

    // Number of elements in a KERNEL x KERNEL window.
    function automatic int k2(input int kernel);
        return kernel * kernel;
    endfunction

    // Sum growth bits the parent normally picks for each legal kernel size.
    function automatic int growth(input int kernel);
        case (kernel)
            1:       return 1;
            3:       return 3;
            5:       return 4;
            7:       return 5;
            default: return 3;
        endcase
    endfunction

    // Width that holds the exact sum of k2 products of n x m bits.
    function automatic int sum_width(input int kernel, input int n, input int m);
        return n + m + $clog2(k2(kernel));
    endfunction

endpackage

// File: rtl/conv_layer_calc_if.sv
// rtl/conv_layer_calc_if.sv - window data/weight input and result output bundle
interface conv_layer_calc_if
    import conv_calc_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int E      = 3
);
    localparam int K2 = k2(KERNEL);

    logic [K2*N-1:0]  data2conv;
    logic             en_in;
    logic [K2*M-1:0]  w;
    logic [N+M+E-1:0] d_out;
    logic             en_out;

    modport master (
        output data2conv,
        output en_in,
        output w,
        input  d_out,
        input  en_out
    );

    modport slave (
        input  data2conv,
        input  en_in,
        input  w,
        output d_out,
        output en_out
    );
endinterface

// File: rtl/csa_adder_tree.sv
// rtl/csa_adder_tree.sv - combinational carry-save reduction of COUNT operands to one sum
module csa_adder_tree #(
    parameter int COUNT = 9,
    parameter int W     = 8,
    parameter int E     = $clog2(COUNT)
) (
    input  logic [COUNT-1:0][W-1:0] operands,
    output logic [W+E-1:0]          sum
);
    localparam int OW = W + E;
    // At least two slots so the final carry-propagate add always has two inputs.
    localparam int CW = (COUNT < 2) ? 2 : COUNT;

    // 3:2 compressor levels until two rows remain, then one carry-propagate add.
    always_comb begin
        logic [OW-1:0] ops [CW];
        logic [OW-1:0] nxt [CW];
        int n;
        int g;
        int r;
        for (int i = 0; i < CW; i++) begin
            ops[i] = '0;
            nxt[i] = '0;
        end
        for (int i = 0; i < COUNT; i++) begin
            ops[i] = OW'(operands[i]);
        end
        n = COUNT;
        g = 0;
        r = 0;
        for (int lvl = 0; lvl < CW; lvl++) begin
            if (n > 2) begin
                g = n / 3;
                r = n % 3;
                for (int i = 0; i < CW; i++) begin
                    nxt[i] = '0;
                end
                for (int i = 0; i < CW / 3; i++) begin
                    if (i < g) begin
                        nxt[2*i]   = ops[3*i] ^ ops[3*i+1] ^ ops[3*i+2];
                        nxt[2*i+1] = ((ops[3*i] & ops[3*i+1]) |
                                      (ops[3*i] & ops[3*i+2]) |
                                      (ops[3*i+1] & ops[3*i+2])) << 1;
                    end
                end
                // Operands left over from the triples pass straight to the next level.
                for (int k = 0; k < 2; k++) begin
                    if (k < r) begin
                        nxt[2*g+k] = ops[3*g+k];
                    end
                end
                ops = nxt;
                n   = 2 * g + r;
            end
        end
        sum = ops[0] + ops[1];
    end
endmodule

// File: rtl/conv_layer_calc.sv
// rtl/conv_layer_calc.sv - two-stage window dot product; CONV_CALC_SAT_EN selects saturation over wrap
module conv_layer_calc
    import conv_calc_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int E      = 3,
    parameter int N      = 4,
    parameter int M      = 4
) (
    input logic              clk,
    input logic              rst,
    conv_layer_calc_if.slave bus
);
    localparam int K2 = k2(KERNEL);
    localparam int PW = N + M;
    localparam int SW = sum_width(KERNEL, N, M);
    localparam int OW = N + M + E;
    localparam int XW = (SW > OW) ? SW : OW;

    logic [K2-1:0][PW-1:0] prod_d;
    logic [K2-1:0][PW-1:0] prod_q;
    logic                  v1_q;
    logic [SW-1:0]         sum_full;
    logic [XW-1:0]         sum_ext;
    logic [OW-1:0]         sum_red;
    logic [OW-1:0]         d_q;
    logic                  v2_q;

    // Element-wise exact products of the window.
    always_comb begin
        for (int j = 0; j < K2; j++) begin
            prod_d[j] = PW'(bus.data2conv[j*N +: N]) * PW'(bus.w[j*M +: M]);
        end
    end

    // Stage 1: capture products only for valid windows; the valid flag always advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= bus.en_in;
            if (bus.en_in) begin
                prod_q <= prod_d;
            end
        end
    end

    csa_adder_tree #(
        .COUNT (K2),
        .W     (PW),
        .E     (SW - PW)
    ) u_tree (
        .operands (prod_q),
        .sum      (sum_full)
    );

    // Fit the full-precision sum into the output width.
    always_comb begin
        sum_ext = XW'(sum_full);
`ifdef CONV_CALC_SAT_EN
        if ((sum_ext >> OW) != '0) begin
            sum_red = '1;
        end else begin
            sum_red = sum_ext[OW-1:0];
        end
`else
        sum_red = sum_ext[OW-1:0];
`endif
    end

    // Stage 2: result register updates only behind a valid stage-1 window.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                d_q <= sum_red;
            end
        end
    end

    assign bus.d_out  = d_q;
    assign bus.en_out = v2_q;
endmodule

// File: tb/tb_conv_layer_calc.sv
// tb/tb_conv_layer_calc.sv - directed vector bench for conv_layer_calc (E=3 and E=2 instances)
module tb_conv_layer_calc;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    conv_layer_calc_if #(.KERNEL(3), .N(4), .M(4), .E(3)) bus3 ();
    conv_layer_calc_if #(.KERNEL(3), .N(4), .M(4), .E(2)) bus2 ();

    conv_layer_calc #(.KERNEL(3), .E(3), .N(4), .M(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    conv_layer_calc #(.KERNEL(3), .E(2), .N(4), .M(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] data;
        logic [35:0] wt;
        int          sum;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [35:0] pack_const(input int v);
        logic [35:0] p;
        for (int j = 0; j < 9; j++) p[j*4 +: 4] = 4'(v);
        return p;
    endfunction

    function automatic logic [35:0] pack_ramp();
        logic [35:0] p;
        for (int j = 0; j < 9; j++) p[j*4 +: 4] = 4'(j);
        return p;
    endfunction

    function automatic logic [35:0] pack_rev();
        logic [35:0] p;
        for (int j = 0; j < 9; j++) p[j*4 +: 4] = 4'(8 - j);
        return p;
    endfunction

    function automatic logic [35:0] pack_alt();
        logic [35:0] p;
        for (int j = 0; j < 9; j++) p[j*4 +: 4] = (j % 2 == 0) ? 4'd15 : 4'd0;
        return p;
    endfunction

    function automatic int exp_e3(input int s);
        return s % 2048;
    endfunction

    function automatic int exp_e2(input int s);
`ifdef CONV_CALC_SAT_EN
        return (s >= 1024) ? 1023 : s;
`else
        return s % 1024;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [35:0] data, input logic [35:0] wt);
        bus3.en_in     = en;
        bus3.data2conv = data;
        bus3.w         = wt;
        bus2.en_in     = en;
        bus2.data2conv = data;
        bus2.w         = wt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input int en, input int s);
        check({name, " en_out"}, int'(bus3.en_out), en);
        check({name, " d_out"}, int'(bus3.d_out), exp_e3(s));
        check({name, " en_out e2"}, int'(bus2.en_out), en);
        check({name, " d_out e2"}, int'(bus2.d_out), exp_e2(s));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(1'b0, '0, '0);

        vecs[0] = '{data: pack_const(1),  wt: pack_const(1),  sum: 9};
        vecs[1] = '{data: pack_ramp(),    wt: pack_const(1),  sum: 36};
        vecs[2] = '{data: pack_ramp(),    wt: pack_const(2),  sum: 72};
        vecs[3] = '{data: pack_const(15), wt: pack_const(15), sum: 2025};
        vecs[4] = '{data: pack_ramp(),    wt: pack_rev(),     sum: 84};
        vecs[5] = '{data: pack_alt(),     wt: pack_const(15), sum: 1125};

        // Reset held three cycles with valid random traffic: outputs stay cleared.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom(), 4'($urandom())}, {$urandom(), 4'($urandom())});
            step();
            check_out("reset", 0, 0);
        end
        rst = 1'b0;
        drive(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("post reset", 0, 0);
        end

        // Single unit-window pulse: en_out exactly two cycles later, value held after.
        drive(1'b1, pack_const(1), pack_const(1));
        step();
        drive(1'b0, '0, '0);
        check_out("unit t+1", 0, 0);
        step();
        check_out("unit t+2", 1, 9);
        step();
        check_out("unit t+3", 0, 9);
        step();
        check_out("unit t+4", 0, 9);

        // Table of windows presented back to back at full throughput.
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(1'b1, vecs[i].data, vecs[i].wt);
            else       drive(1'b0, '0, '0);
            step();
            if (i >= 1) check_out($sformatf("vec%0d", i - 1), 1, vecs[i-1].sum);
        end
        step();
        check_out("table drain", 0, vecs[5].sum);

        // Valid pattern 1,0,1: two separate pulses, d_out held in the gap.
        drive(1'b1, pack_ramp(), pack_const(1));
        step();
        drive(1'b0, '0, '0);
        step();
        drive(1'b1, pack_const(15), pack_const(15));
        check_out("gap first", 1, 36);
        step();
        drive(1'b0, '0, '0);
        check_out("gap hold", 0, 36);
        step();
        check_out("gap second", 1, 2025);
        step();
        check_out("gap after", 0, 2025);

        // Reset one cycle after a window enters: that window never emerges.
        drive(1'b1, pack_ramp(), pack_const(2));
        step();
        drive(1'b0, '0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("midrst in", 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("midrst out", 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_layer_calc.md
# conv_layer_calc

Computes one convolution-window dot product: KERNEL×KERNEL unsigned data samples multiplied element-wise by KERNEL×KERNEL unsigned weights and summed into a single registered result. One instance serves one input feature channel inside the convolution engine. The parent instantiates CL_IN copies and merges their outputs with a cross-channel adder.

## Interface
- KERNEL, 3, window side; legal values 1/3/5/7; window holds K2 = KERNEL*KERNEL elements
- E, 3, sum growth bits set by parent: 1 for KERNEL=1, 3 for 3, 4 for 5, 5 for 7
- N, 4, data element width
- M, 4, weight element width
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- data2conv  input  K2*N  window data; element j at [j*N +: N], unsigned
- en_in  input  1  data2conv/w valid this cycle
- w  input  K2*M  weights; element j at [j*M +: M], unsigned
- d_out  output  N+M+E  registered window sum
- en_out  output  1  d_out updated this cycle

## Operation
- Stage 1: p[j] = data2conv[j] * w[j], each N+M bits unsigned, exact.
- Products register only on cycles where en_in=1; otherwise they hold.
- Stage 2: S = sum of p[0..K2-1], computed at full precision (N+M+ceil(log2 K2)) bits.
- Stage 2 then reduces S to N+M+E bits: default wraps (low N+M+E bits kept), or saturates when SAT is compiled in (see Configuration).
- Sum registers only when the stage-1 valid flag is 1; d_out holds its last value otherwise.
- KERNEL=1: d_out = data*w, zero-extended to N+M+E bits.
- No sign handling and no ReLU; all quantities are unsigned.

## Timing
- Latency: 2 cycles from en_in to en_out; en_in at cycle t gives en_out=1 and the corresponding d_out at cycle t+2.
- en_out is a pure 2-deep delay of en_in; it is never stretched or merged.
- Full throughput: en_in high every cycle gives one result per cycle.
- No backpressure and no stall input.
- While rst=1 at a rising edge, every register is cleared: products, both valid flags, d_out=0 and en_out=0.
- Reset mid-operation discards in-flight windows; none emerge after reset deasserts.
- First output possible 2 cycles after the first post-reset en_in.
- Inputs are sampled only at rising edges with en_in=1; input values while en_in=0 are don't-care.

## Configuration
- Macro CONV_CALC_SAT_EN.
- Defined: if S ≥ 2^(N+M+E), d_out = all ones (2^(N+M+E)-1).
- Undefined: d_out = S mod 2^(N+M+E).
- Latency and valid timing are identical in both builds.

## Structure
- Package conv_calc_pkg:
  - function k2(KERNEL)
  - function growth(KERNEL) returning the E table above
  - function clog2-based full-precision sum width
- Sub-module csa_adder_tree:
  - parameters COUNT, W, E
  - reduces COUNT W-bit operands through 3:2 carry-save compressor levels plus one final carry-propagate add
  - combinational, full-precision output
  - reused by the parent for cross-channel summation
- Top: product generate loop, stage-1 registers, csa_adder_tree, reduction/saturation, stage-2 register, valid pipeline.

## Test plan
All scenarios use N=4, M=4, KERNEL=3, E=3 (d_out 11 bits) unless stated.
- Reset: hold rst 3 cycles with en_in=1 and random data → d_out=0, en_out=0 during reset and the cycle after; no stale valid appears.
- Unit window: all data=1, w=1, single en_in pulse at t → en_out=1 only at t+2, d_out=9, held after.
- Ramp: data[j]=j (0..8), w=1 → 36; then w[j]=2 → 72, presented on back-to-back cycles → consecutive outputs 36, 72.
- Max: all data=15, w=15 → 2025 with en_out=1.
- Overflow build with E=2 (10-bit out), all 15s:
  - without CONV_CALC_SAT_EN → 1001 (2025 mod 1024)
  - with CONV_CALC_SAT_EN → 1023
- Gaps and mid-flight reset:
  - en_in pattern 1,0,1 → exactly two en_out pulses 2 cycles later, with d_out held between them
  - rst asserted one cycle after an en_in → no en_out is ever produced for that window
